sad_accum_array: RTL and testbench
==================================

SAD_ACCUM_ARRAY -- requirements
Module: sad_accum_array

Interface
REQ-001 The block SHALL have parameter PIX_W, default 8, meaning pixel width in bits.
REQ-002 The block SHALL have parameter SUM_W, default 12, meaning accumulator width, with SUM_W >= PIX_W+4.
REQ-003 clk  input  1  clock; all state updates on rising edge.
REQ-004 rst_n  input  1  reset, synchronous, active-low.
REQ-005 start  input  1  begin a new 4x4 block; sampled only in IDLE, or in HOLD during the output handshake cycle.
REQ-006 pix_valid  input  1  cur_pix/ref_pix beat valid.
REQ-007 pix_ready  output  1  block accepts a pixel beat.
REQ-008 cur_pix  input  PIX_W  current-block pixel, raster order.
REQ-009 ref_pix  input  16*PIX_W  lane k (bits k*PIX_W +: PIX_W) is the reference pixel for candidate k.
REQ-010 sums_valid  output  1  sum0..sum15 are complete and stable.
REQ-011 sums_ready  input  1  downstream comparator accepts the sums.
REQ-012 sum0..sum15  output  SUM_W each  SAD of candidate k; candidate k has vertical offset k[3:2] and horizontal offset k[1:0].

Function
REQ-013 The FSM SHALL have three states: IDLE, ACCUM and HOLD.
REQ-014 In IDLE, pix_ready=0 and sums_valid=0; start=1 SHALL clear all sums and the beat counter to 0 and enter ACCUM on the next cycle.
REQ-015 In ACCUM, pix_ready=1; a beat occurs when pix_valid=1 and pix_ready=1.
REQ-016 On each beat, every sum_k SHALL update to sum_k + |cur_pix - ref lane k|, with the unsigned absolute difference zero-extended to SUM_W, and the 4-bit beat counter SHALL increment.
REQ-017 Cycles with pix_valid=0 in ACCUM SHALL leave the sums and the counter unchanged.
REQ-018 On the 16th beat (counter==15), the FSM SHALL enter HOLD, and sums_valid=1 from the next cycle.
REQ-019 In HOLD, pix_ready=0, sums SHALL be held constant, and sums_valid SHALL stay 1 until sums_valid=1 and sums_ready=1.
REQ-020 On the HOLD handshake cycle with start=0, the FSM SHALL go to IDLE; sums_valid=0 the next cycle; sum values are retained until the next start.
REQ-021 On the HOLD handshake cycle with start=1, the FSM SHALL clear the sums and counter and enter ACCUM directly (back-to-back, no IDLE cycle).
REQ-022 start SHALL be ignored in ACCUM and in HOLD without sums_ready.
REQ-023 No overflow SHALL occur: maximum sum is 16*(2^PIX_W-1) = 4080 at defaults; no saturation logic.
REQ-024 Latency: with start at cycle 0 and continuous pix_valid, beats fall on cycles 1..16 and sums_valid=1 at cycle 17.
REQ-025 Throughput: one beat per cycle in ACCUM, with no bubbles between beats.

Reset
REQ-026 With rst_n=0 at a clock edge, the block SHALL enter IDLE with sum0..sum15=0, counter=0, sums_valid=0 and pix_ready=0, overriding all other inputs.
REQ-027 Reset mid-ACCUM or mid-HOLD SHALL discard the partial or pending block; the first start after reset SHALL behave as from power-up.

Verification
REQ-028 Identical data: cur_pix=ref lanes=0x40 for 16 beats -> all sums 0x000, sums_valid=1 at cycle 17.
REQ-029 Maximum: cur_pix=0xFF, all lanes 0x00 for 16 beats -> all sums 0xFF0 (4080), no wrap.
REQ-030 Distinct minimum: lane 5=cur+3, other lanes=cur+10 -> sum5=48 (0x030), others 160 (0x0A0).
REQ-031 Gapped input: pix_valid toggling every other cycle -> same sums as REQ-030; sums_valid only after the 16th accepted beat.
REQ-032 Backpressure: sums_ready low 5 cycles with start pulsed -> sums and sums_valid stable, start ignored; then sums_ready=1 and start=1 together -> ACCUM next cycle with sums cleared.
REQ-033 Reset at beat 7 -> next cycle IDLE, sums 0, pix_ready=0; a new start then completes a block normally.

Source files
------------

// File: rtl/sad_accum_array.sv
// sad_accum_array: 16-candidate 4x4 sum-of-absolute-differences accumulator with valid/ready handshakes
module sad_accum_array #(
  parameter int PIX_W = 8,
  parameter int SUM_W = 12
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic                 pix_valid,
  output logic                 pix_ready,
  input  logic [PIX_W-1:0]     cur_pix,
  input  logic [16*PIX_W-1:0]  ref_pix,
  output logic                 sums_valid,
  input  logic                 sums_ready,
  output logic [SUM_W-1:0]     sum0,
  output logic [SUM_W-1:0]     sum1,
  output logic [SUM_W-1:0]     sum2,
  output logic [SUM_W-1:0]     sum3,
  output logic [SUM_W-1:0]     sum4,
  output logic [SUM_W-1:0]     sum5,
  output logic [SUM_W-1:0]     sum6,
  output logic [SUM_W-1:0]     sum7,
  output logic [SUM_W-1:0]     sum8,
  output logic [SUM_W-1:0]     sum9,
  output logic [SUM_W-1:0]     sum10,
  output logic [SUM_W-1:0]     sum11,
  output logic [SUM_W-1:0]     sum12,
  output logic [SUM_W-1:0]     sum13,
  output logic [SUM_W-1:0]     sum14,
  output logic [SUM_W-1:0]     sum15
);
  typedef enum logic [1:0] {IDLE, ACCUM, HOLD} state_t;
  state_t           state_q, state_d;
  logic [3:0]       cnt_q, cnt_d;
  logic [SUM_W-1:0] sum_q [16];
  logic [SUM_W-1:0] sum_d [16];
  logic [PIX_W-1:0] diff [16];
  logic             beat, clr;
  // state, beat counter and all sixteen accumulators
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      for (int k = 0; k < 16; k++) sum_q[k] <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      for (int k = 0; k < 16; k++) sum_q[k] <= sum_d[k];
    end
  end
  // next state: the 16th beat closes the block, a HOLD handshake with start chains straight into ACCUM
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    state_d = start ? ACCUM : IDLE;
      ACCUM:   state_d = (beat && cnt_q == 4'd15) ? HOLD : ACCUM;
      HOLD:    state_d = sums_ready ? (start ? ACCUM : IDLE) : HOLD;
      default: state_d = IDLE;
    endcase
  end
  // outputs and datapath controls decoded from the current state
  always_comb begin
    pix_ready  = state_q == ACCUM;
    sums_valid = state_q == HOLD;
    beat       = (state_q == ACCUM) && pix_valid;
    clr        = start && ((state_q == IDLE) || ((state_q == HOLD) && sums_ready));
  end
  // per-candidate unsigned absolute difference against the current pixel
  always_comb begin
    for (int k = 0; k < 16; k++)
      diff[k] = (cur_pix >= ref_pix[k*PIX_W +: PIX_W]) ? cur_pix - ref_pix[k*PIX_W +: PIX_W]
                                                     : ref_pix[k*PIX_W +: PIX_W] - cur_pix;
  end
  // accumulate on each beat; a new block clears everything, otherwise values are held
  always_comb begin
    cnt_d = clr ? 4'd0 : beat ? cnt_q + 4'd1 : cnt_q;
    for (int k = 0; k < 16; k++)
      sum_d[k] = clr ? '0 : beat ? sum_q[k] + SUM_W'(diff[k]) : sum_q[k];
  end
  assign sum0  = sum_q[0];
  assign sum1  = sum_q[1];
  assign sum2  = sum_q[2];
  assign sum3  = sum_q[3];
  assign sum4  = sum_q[4];
  assign sum5  = sum_q[5];
  assign sum6  = sum_q[6];
  assign sum7  = sum_q[7];
  assign sum8  = sum_q[8];
  assign sum9  = sum_q[9];
  assign sum10 = sum_q[10];
  assign sum11 = sum_q[11];
  assign sum12 = sum_q[12];
  assign sum13 = sum_q[13];
  assign sum14 = sum_q[14];
  assign sum15 = sum_q[15];
endmodule

// File: tb/tb_sad_accum_array.sv
// tb_sad_accum_array: table vectors, handshake corner cases and randomized blocks against an arithmetic SAD model
module tb_sad_accum_array;
  localparam int PIX_W = 8;
  localparam int SUM_W = 12;
  typedef struct {
    logic [7:0]  cur;
    logic [7:0]  lane;
    logic [7:0]  lane5;
    logic [11:0] exp_o;
    logic [11:0] exp5;
  } vec_t;
  logic clk = 0, rst_n = 0, start = 0, pix_valid = 0, sums_ready = 0;
  logic [PIX_W-1:0] cur_pix = '0;
  logic [16*PIX_W-1:0] ref_pix = '0;
  logic pix_ready, sums_valid;
  logic [SUM_W-1:0] s [16];
  int vectors = 0, miscompares = 0;
  int exp_sum [16];
  logic [7:0] bcur [16];
  logic [7:0] bref [16][16];
  vec_t tbl [4];
  bit in_accum;
  always #5 clk = ~clk;
  sad_accum_array #(.PIX_W(PIX_W), .SUM_W(SUM_W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .pix_valid(pix_valid), .pix_ready(pix_ready),
    .cur_pix(cur_pix), .ref_pix(ref_pix), .sums_valid(sums_valid), .sums_ready(sums_ready),
    .sum0(s[0]), .sum1(s[1]), .sum2(s[2]), .sum3(s[3]), .sum4(s[4]), .sum5(s[5]),
    .sum6(s[6]), .sum7(s[7]), .sum8(s[8]), .sum9(s[9]), .sum10(s[10]), .sum11(s[11]),
    .sum12(s[12]), .sum13(s[13]), .sum14(s[14]), .sum15(s[15])
  );
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string name, input int act, input int req);
    vectors++;
    if (act != req) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d", name, act, req);
    end
  endtask
  task automatic chk_sums(input string name);
    for (int k = 0; k < 16; k++) chk($sformatf("%s sum%0d", name, k), int'(s[k]), exp_sum[k]);
  endtask
  task automatic clear_model();
    for (int k = 0; k < 16; k++) exp_sum[k] = 0;
  endtask
  task automatic model_add(input int i);
    int d;
    for (int k = 0; k < 16; k++) begin
      d = int'(bcur[i]) - int'(bref[i][k]);
      exp_sum[k] += (d < 0) ? -d : d;
    end
  endtask
  task automatic drive_beat(input int i);
    cur_pix = bcur[i];
    for (int k = 0; k < 16; k++) ref_pix[k*PIX_W +: PIX_W] = bref[i][k];
  endtask
  task automatic fill_const(input vec_t v);
    for (int i = 0; i < 16; i++) begin
      bcur[i] = v.cur;
      for (int k = 0; k < 16; k++) bref[i][k] = (k == 5) ? v.lane5 : v.lane;
    end
  endtask
  task automatic fill_rand();
    for (int i = 0; i < 16; i++) begin
      bcur[i] = 8'($urandom);
      for (int k = 0; k < 16; k++) bref[i][k] = 8'($urandom);
    end
  endtask
  task automatic start_block();
    start = 1;
    pix_valid = 0;
    tick();
    start = 0;
    clear_model();
    chk("start pix_ready", int'(pix_ready), 1);
    chk("start sums_valid", int'(sums_valid), 0);
    chk_sums("start clear");
  endtask
  // mode 0: continuous, 1: valid every other cycle, 2: random gaps with random start noise
  task automatic feed(input int mode);
    int i, guard;
    bit v;
    i = 0;
    guard = 0;
    while (i < 16 && guard < 400) begin
      v = (mode == 0) ? 1'b1 : (mode == 1) ? (guard % 2 == 0) : ($urandom_range(0, 2) != 0);
      pix_valid = v;
      start = (mode == 2) ? 1'($urandom_range(0, 1)) : 1'b0;
      if (v) drive_beat(i);
      else begin
        cur_pix = 8'($urandom);
        ref_pix = {$urandom, $urandom, $urandom, $urandom};
      end
      if (v) begin
        model_add(i);
        i++;
      end
      guard++;
      tick();
      if (i < 16) begin
        chk("accum sums_valid", int'(sums_valid), 0);
        chk("accum pix_ready", int'(pix_ready), 1);
      end
    end
    pix_valid = 0;
    start = 0;
    chk("feed beats", i, 16);
    chk("done sums_valid", int'(sums_valid), 1);
    chk("done pix_ready", int'(pix_ready), 0);
    chk_sums("done");
  endtask
  task automatic finish_hold(input int delay, input bit restart);
    for (int d = 0; d < delay; d++) begin
      sums_ready = 0;
      start = 1'($urandom_range(0, 1));
      pix_valid = 1'($urandom);
      tick();
      chk("hold sums_valid", int'(sums_valid), 1);
      chk("hold pix_ready", int'(pix_ready), 0);
      chk_sums("hold");
    end
    sums_ready = 1;
    start = restart;
    pix_valid = 0;
    tick();
    sums_ready = 0;
    start = 0;
    if (restart) begin
      clear_model();
      chk("restart pix_ready", int'(pix_ready), 1);
      chk("restart sums_valid", int'(sums_valid), 0);
      chk_sums("restart clear");
    end else begin
      chk("idle sums_valid", int'(sums_valid), 0);
      chk("idle pix_ready", int'(pix_ready), 0);
      chk_sums("idle retain");
      pix_valid = 1;
      tick();
      pix_valid = 0;
      chk("idle ignore pix_ready", int'(pix_ready), 0);
      chk_sums("idle ignore");
    end
  endtask
  initial begin
    tbl[0] = '{8'h40, 8'h40, 8'h40, 12'h000, 12'h000};
    tbl[1] = '{8'hFF, 8'h00, 8'h00, 12'hFF0, 12'hFF0};
    tbl[2] = '{8'h20, 8'h2A, 8'h23, 12'h0A0, 12'h030};
    tbl[3] = '{8'h80, 8'h70, 8'h90, 12'h100, 12'h100};
    rst_n = 0;
    start = 1;
    pix_valid = 1;
    sums_ready = 1;
    tick();
    tick();
    rst_n = 1;
    start = 0;
    pix_valid = 0;
    sums_ready = 0;
    clear_model();
    chk("reset sums_valid", int'(sums_valid), 0);
    chk("reset pix_ready", int'(pix_ready), 0);
    chk_sums("reset");
    for (int v = 0; v < 4; v++) begin
      fill_const(tbl[v]);
      start_block();
      feed(0);
      for (int k = 0; k < 16; k++)
        chk($sformatf("table%0d sum%0d", v, k), int'(s[k]), int'((k == 5) ? tbl[v].exp5 : tbl[v].exp_o));
      finish_hold(v, 1'b0);
    end
    fill_const(tbl[2]);
    start_block();
    feed(1);
    for (int k = 0; k < 16; k++)
      chk($sformatf("gapped sum%0d", k), int'(s[k]), int'((k == 5) ? tbl[2].exp5 : tbl[2].exp_o));
    finish_hold(5, 1'b1);
    fill_rand();
    feed(2);
    finish_hold(2, 1'b0);
    fill_rand();
    start_block();
    for (int i = 0; i < 7; i++) begin
      pix_valid = 1;
      drive_beat(i);
      tick();
    end
    rst_n = 0;
    pix_valid = 1;
    start = 1;
    sums_ready = 1;
    tick();
    rst_n = 1;
    pix_valid = 0;
    start = 0;
    sums_ready = 0;
    clear_model();
    chk("midreset pix_ready", int'(pix_ready), 0);
    chk("midreset sums_valid", int'(sums_valid), 0);
    chk_sums("midreset");
    tick();
    chk("midreset idle pix_ready", int'(pix_ready), 0);
    fill_rand();
    start_block();
    feed(0);
    finish_hold(0, 1'b0);
    in_accum = 0;
    for (int b = 0; b < 10; b++) begin
      bit r;
      if (!in_accum) start_block();
      fill_rand();
      feed((b % 3 == 0) ? 0 : 2);
      r = 1'($urandom_range(0, 1));
      finish_hold(int'($urandom_range(0, 4)), r);
      in_accum = r;
    end
    if (in_accum) begin
      fill_rand();
      feed(0);
      finish_hold(0, 1'b0);
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end
endmodule
